// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// Contents:
//   opcode, func  - instruction fields from the instruction register
//   zero          - ALU zero flag
//   mem_ready     - memory access completion
//   pc_write .. pc_src, alu_src_b, alu_op - datapath strobes and mux selects
//   instr_done, trap, state, instr_count  - status back to the system
// Modport master is the controller; modport slave is the datapath side.
interface multicycle_controller_if;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        reg_dst;
  logic        reg_write;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic        pc_src;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        instr_done;
  logic        trap;
  logic [3:0]  state;
  logic [31:0] instr_count;

  modport master (
    input  opcode, func, zero, mem_ready,
    output pc_write, ir_write, iord, mem_read, mem_write, reg_dst,
           reg_write, mem_to_reg, alu_src_a, pc_src, alu_src_b, alu_op,
           instr_done, trap, state, instr_count
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  pc_write, ir_write, iord, mem_read, mem_write, reg_dst,
           reg_write, mem_to_reg, alu_src_a, pc_src, alu_src_b, alu_op,
           instr_done, trap, state, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM (R-type, lw, sw, beq).
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset; forces IDLE immediately
//   bus  - multicycle_controller_if.master: instruction fields, zero flag,
//          mem_ready in; datapath strobes, retire pulse, trap, state code
//          and retired-instruction count out
// Parameter MEM_TIMEOUT: memory wait cycles allowed before trapping
// (0 disables the timeout).
// Strobes are decoded combinationally from the state register (plus the
// few fields qualified by mem_ready/zero/func), so an asynchronous reset
// removes every strobe without waiting for a clock edge.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_BRANCH = 4'd9,
    ST_TRAP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [7:0] TIMEOUT_C    = 8'(MEM_TIMEOUT);
  localparam logic       TIMEOUT_EN_C = (MEM_TIMEOUT != 0);

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  wait_cnt_r;
  logic        trap_r;
  logic [31:0] instr_count_r;
  logic        timeout_s;
  logic        func_ok_s;
  logic [1:0]  func_op_s;
  logic        wait_state_s;
  logic        enter_wait_s;
  logic        instr_done_s;

  // Map an R-type func field to {supported, alu_op}.
  function automatic logic [2:0] decode_func(input logic [5:0] f);
    logic [2:0] r;
    case (f)
      6'b100000: r = 3'b1_00;  // add
      6'b100010: r = 3'b1_01;  // sub
      6'b100100: r = 3'b1_10;  // and
      6'b100101: r = 3'b1_11;  // or
      default:   r = 3'b0_00;
    endcase
    return r;
  endfunction

  // Decode the func field once; used by both next-state and output logic.
  always_comb begin
    {func_ok_s, func_op_s} = decode_func(bus.func);
  end

  // Next-state logic. Wait states give the normal transition priority over
  // the timeout when mem_ready arrives on the limit cycle.
  always_comb begin
    next_state_s = state_r;
    timeout_s    = TIMEOUT_EN_C && (wait_cnt_r == TIMEOUT_C) && !bus.mem_ready;
    case (state_r)
      ST_IDLE: next_state_s = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready)  next_state_s = ST_DECODE;
        else if (timeout_s) next_state_s = ST_TRAP;
        else                next_state_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     next_state_s = ST_EXEC;
          OP_LW, OP_SW: next_state_s = ST_MEMADR;
          OP_BEQ:       next_state_s = ST_BRANCH;
          default:      next_state_s = ST_TRAP;
        endcase
      end
      ST_MEMADR: begin
        case (bus.opcode)
          OP_LW:   next_state_s = ST_MEMRD;
          OP_SW:   next_state_s = ST_MEMWR;
          default: next_state_s = ST_TRAP;
        endcase
      end
      ST_MEMRD: begin
        if (bus.mem_ready)  next_state_s = ST_MEMWB;
        else if (timeout_s) next_state_s = ST_TRAP;
        else                next_state_s = ST_MEMRD;
      end
      ST_MEMWB: next_state_s = ST_FETCH;
      ST_MEMWR: begin
        if (bus.mem_ready)  next_state_s = ST_FETCH;
        else if (timeout_s) next_state_s = ST_TRAP;
        else                next_state_s = ST_MEMWR;
      end
      ST_EXEC: begin
        if (func_ok_s) next_state_s = ST_RWB;
        else           next_state_s = ST_TRAP;
      end
      ST_RWB:    next_state_s = ST_FETCH;
      ST_BRANCH: next_state_s = ST_FETCH;
      ST_TRAP:   next_state_s = ST_TRAP;
      // Unused codes fall into TRAP rather than wandering.
      default:   next_state_s = ST_TRAP;
    endcase
  end

  // Wait-counter control: clear on entering a memory wait state, count
  // stalled cycles while staying in one.
  always_comb begin
    wait_state_s = (state_r == ST_FETCH) || (state_r == ST_MEMRD) ||
                   (state_r == ST_MEMWR);
    enter_wait_s = ((next_state_s == ST_FETCH) || (next_state_s == ST_MEMRD) ||
                    (next_state_s == ST_MEMWR)) && (next_state_s != state_r);
  end

  // State register, wait counter, sticky trap flag and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= 8'd0;
      trap_r        <= 1'b0;
      instr_count_r <= 32'd0;
    end else begin
      state_r <= next_state_s;
      trap_r  <= (next_state_s == ST_TRAP);
      if (enter_wait_s) begin
        wait_cnt_r <= 8'd0;
      end else if (wait_state_s && !bus.mem_ready && (wait_cnt_r != 8'hFF)) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (instr_done_s) instr_count_r <= instr_count_r + 32'd1;
      else              instr_count_r <= instr_count_r;
    end
  end

  // Output decode from the current state; anything not set stays 0.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.pc_src     = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    instr_done_s   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      ST_DECODE: bus.alu_src_b = 2'b11;
      ST_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = func_op_s;
      end
      ST_RWB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        instr_done_s  = 1'b1;
      end
      ST_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      ST_MEMRD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
      end
      ST_MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        instr_done_s   = 1'b1;
      end
      ST_MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        instr_done_s  = bus.mem_ready;
      end
      ST_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_src    = 1'b1;
        bus.pc_write  = bus.zero;
        instr_done_s  = 1'b1;
      end
      default: instr_done_s = 1'b0;
    endcase
  end

  assign bus.instr_done  = instr_done_s;
  assign bus.trap        = trap_r;
  assign bus.state       = state_r;
  assign bus.instr_count = instr_count_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller (MEM_TIMEOUT = 3).
// Stimulus pushes hand-written expected {state, control word, count} for
// each cycle; a negedge monitor pops and compares.
// Control word bit order (MSB..LSB): pc_write ir_write iord mem_read
// mem_write reg_dst reg_write mem_to_reg alu_src_a pc_src alu_src_b[1:0]
// alu_op[1:0] instr_done trap.
module tb_multicycle_controller;
  logic clk;
  logic rst;
  multicycle_controller_if bus();

  multicycle_controller #(.MEM_TIMEOUT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          errors;
  int          idx;
  logic [31:0] exp_cnt;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
    S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6,
    S_EXEC = 4'd7, S_RWB = 4'd8, S_BRANCH = 4'd9, S_TRAP = 4'd10;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the DUT against the oldest expectation each cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {bus.pc_write, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
             bus.reg_dst, bus.reg_write, bus.mem_to_reg, bus.alu_src_a,
             bus.pc_src, bus.alu_src_b, bus.alu_op, bus.instr_done, bus.trap};
      checks = checks + 3;
      if (bus.state !== e.st) begin
        errors = errors + 1;
        $display("FAIL state step=%0d got=%0d want=%0d", idx, bus.state, e.st);
      end
      if (act !== e.ctrl) begin
        errors = errors + 1;
        $display("FAIL ctrl step=%0d got=%h want=%h", idx, act, e.ctrl);
      end
      if (bus.instr_count !== e.cnt) begin
        errors = errors + 1;
        $display("FAIL count step=%0d got=%0d want=%0d", idx, bus.instr_count, e.cnt);
      end
      idx = idx + 1;
    end
  end

  // One clock cycle of stimulus plus the expected DUT view in that cycle.
  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input logic [3:0] st,
                      input logic [15:0] ctrl);
    exp_t e;
    rst = r;
    if (r) exp_cnt = 32'd0;
    bus.opcode    = op;
    bus.func      = fn;
    bus.zero      = z;
    bus.mem_ready = mr;
    e.st   = st;
    e.ctrl = ctrl;
    e.cnt  = exp_cnt;
    exp_q.push_back(e);
    if (ctrl[1]) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, S_IDLE, 16'h0000);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, S_IDLE, 16'h0000);
  endtask

  task automatic run_rtype(input logic [5:0] fn, input logic [15:0] exec_ctrl);
    step(1'b0, 6'h00, fn, 1'b0, 1'b1, S_FETCH,  16'hD010);
    step(1'b0, 6'h00, fn, 1'b0, 1'b1, S_DECODE, 16'h0030);
    step(1'b0, 6'h00, fn, 1'b0, 1'b1, S_EXEC,   exec_ctrl);
    step(1'b0, 6'h00, fn, 1'b0, 1'b1, S_RWB,    16'h0602);
  endtask

  task automatic run_beq(input logic z, input logic [15:0] br_ctrl);
    step(1'b0, 6'h04, 6'h00, z, 1'b1, S_FETCH,  16'hD010);
    step(1'b0, 6'h04, 6'h00, z, 1'b1, S_DECODE, 16'h0030);
    step(1'b0, 6'h04, 6'h00, z, 1'b1, S_BRANCH, br_ctrl);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    idx     = 0;
    exp_cnt = 32'd0;
    rst = 1'b1;
    bus.opcode = 6'h00; bus.func = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 6'h00, 6'h00, 1'b0, 1'b1, S_IDLE, 16'h0000);
    do_reset();

    // R-type sub, add, and, or with memory always ready.
    run_rtype(6'b100010, 16'h0084);
    run_rtype(6'b100000, 16'h0080);
    run_rtype(6'b100100, 16'h0088);
    run_rtype(6'b100101, 16'h008C);

    // lw with three stalled MEMRD cycles: 8 cycles in total.
    step(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, S_FETCH,  16'hD010);
    step(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, S_DECODE, 16'h0030);
    step(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, S_MEMADR, 16'h00A0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, S_MEMRD, 16'h3000);
    step(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, S_MEMRD,  16'h3000);
    step(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, S_MEMWB,  16'h0302);

    // sw with memory ready: retires in MEMWR.
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, S_FETCH,  16'hD010);
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, S_DECODE, 16'h0030);
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, S_MEMADR, 16'h00A0);
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, S_MEMWR,  16'h2802);

    // beq taken, then not taken.
    run_beq(1'b1, 16'h80C6);
    run_beq(1'b0, 16'h00C6);

    // Fetch stalls 3 cycles, ready on the limit cycle: normal path wins.
    for (int i = 0; i < 3; i++)
      step(1'b0, 6'h00, 6'b100101, 1'b0, 1'b0, S_FETCH, 16'h1010);
    step(1'b0, 6'h00, 6'b100101, 1'b0, 1'b1, S_FETCH,  16'hD010);
    step(1'b0, 6'h00, 6'b100101, 1'b0, 1'b1, S_DECODE, 16'h0030);
    step(1'b0, 6'h00, 6'b100101, 1'b0, 1'b1, S_EXEC,   16'h008C);
    step(1'b0, 6'h00, 6'b100101, 1'b0, 1'b1, S_RWB,    16'h0602);

    // Unsupported func traps from EXEC.
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, S_FETCH,  16'hD010);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, S_DECODE, 16'h0030);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, S_EXEC,   16'h0080);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, S_TRAP,   16'h0001);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, S_TRAP,   16'h0001);
    do_reset();

    // Fetch timeout: 4th stalled cycle goes to TRAP.
    for (int i = 0; i < 4; i++)
      step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, S_FETCH, 16'h1010);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, S_TRAP, 16'h0001);
    do_reset();

    // Illegal opcode traps after DECODE and stays trapped.
    step(1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, S_FETCH,  16'hD010);
    step(1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, S_DECODE, 16'h0030);
    for (int i = 0; i < 10; i++)
      step(1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, S_TRAP, 16'h0001);
    do_reset();

    // Reset in the middle of a stalled sw: strobes drop, nothing retires.
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, S_FETCH,  16'hD010);
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, S_DECODE, 16'h0030);
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, S_MEMADR, 16'h00A0);
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, S_MEMWR,  16'h2800);
    step(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, S_IDLE,   16'h0000);
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, S_IDLE,   16'h0000);
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, S_FETCH,  16'hD010);

    @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
